// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - log2(WIDTH)-stage pipelined barrel shifter (LSL/LSR/ASR/ROR) with carry; optional SHIFTER_BYPASS_EN
module pipelined_barrel_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry
);

    localparam int LAST = SHAMT_W - 1;

    // Stage registers: index k holds the result of shift stage k.
    logic [WIDTH-1:0]   q_data  [SHAMT_W];
    logic [SHAMT_W-1:0] q_shamt [SHAMT_W];
    logic [1:0]         q_mode  [SHAMT_W];
    logic               q_carry [SHAMT_W];
    logic               q_valid [SHAMT_W];

    // Next values for each stage register.
    logic [WIDTH-1:0]   n_data  [SHAMT_W];
    logic [SHAMT_W-1:0] n_shamt [SHAMT_W];
    logic [1:0]         n_mode  [SHAMT_W];
    logic               n_carry [SHAMT_W];
    logic               n_valid [SHAMT_W];

    logic advance;
    logic bypass;

    // One stage: optionally shift by amt and replace carry with the last bit moved out.
    // Result is {carry, data}.
    function automatic logic [WIDTH:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input logic             c,
        input logic             en,
        input int               amt
    );
        logic [WIDTH-1:0] top_out;
        logic [WIDTH-1:0] low_out;
        logic [WIDTH-1:0] r;
        logic             co;
        top_out = d >> (WIDTH - amt);   // bit 0 is d[WIDTH-amt]
        low_out = d >> (amt - 1);       // bit 0 is d[amt-1]
        r  = d;
        co = c;
        if (en) begin
            case (m)
                2'b00: begin
                    r  = d << amt;
                    co = top_out[0];
                end
                2'b01: begin
                    r  = d >> amt;
                    co = low_out[0];
                end
                2'b10: begin
                    r  = WIDTH'($signed(d) >>> amt);
                    co = low_out[0];
                end
                default: begin
                    r  = (d >> amt) | (d << (WIDTH - amt));
                    co = low_out[0];
                end
            endcase
        end
        return {co, r};
    endfunction

    assign advance   = !q_valid[LAST] || out_ready;
    assign in_ready  = advance;
    assign out_valid = q_valid[LAST];
    assign out_data  = q_data[LAST];
    assign out_carry = q_carry[LAST];

`ifdef SHIFTER_BYPASS_EN
    logic pipe_empty;

    // Bypass is only safe when nothing is in flight, so ordering cannot be broken.
    always_comb begin
        pipe_empty = 1'b1;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (q_valid[k]) begin
                pipe_empty = 1'b0;
            end
        end
    end

    assign bypass = in_valid && out_ready && (in_shamt == '0) && pipe_empty;
`else
    assign bypass = 1'b0;
`endif

    // Per-stage datapath: stage 0 takes the input port, later stages the previous register.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int AMT = 1 << k;

        logic [WIDTH-1:0]   sd;
        logic [SHAMT_W-1:0] ss;
        logic [1:0]         sm;
        logic               sc;
        logic               sv;
        logic [WIDTH:0]     res;

        if (k == 0) begin : g_src_in
            assign sd = in_data;
            assign ss = in_shamt;
            assign sm = in_mode;
            assign sc = 1'b0;
            assign sv = in_valid && !bypass;
        end else begin : g_src_reg
            assign sd = q_data[k-1];
            assign ss = q_shamt[k-1];
            assign sm = q_mode[k-1];
            assign sc = q_carry[k-1];
            assign sv = q_valid[k-1];
        end

        assign res = shift_stage(sd, sm, sc, ss[k], AMT);

        if (k == LAST) begin : g_last
            assign n_data[k]  = bypass ? in_data  : res[WIDTH-1:0];
            assign n_carry[k] = bypass ? 1'b0     : res[WIDTH];
            assign n_shamt[k] = bypass ? in_shamt : ss;
            assign n_mode[k]  = bypass ? in_mode  : sm;
            assign n_valid[k] = bypass || sv;
        end else begin : g_mid
            assign n_data[k]  = res[WIDTH-1:0];
            assign n_carry[k] = res[WIDTH];
            assign n_shamt[k] = ss;
            assign n_mode[k]  = sm;
            assign n_valid[k] = sv;
        end
    end

    // Whole pipeline moves together on advance; reset flushes every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                q_data[k]  <= '0;
                q_shamt[k] <= '0;
                q_mode[k]  <= '0;
                q_carry[k] <= 1'b0;
                q_valid[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                q_data[k]  <= n_data[k];
                q_shamt[k] <= n_shamt[k];
                q_mode[k]  <= n_mode[k];
                q_carry[k] <= n_carry[k];
                q_valid[k] <= n_valid[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - self-checking bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;
`ifdef SHIFTER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_carry;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    // Reference: each result bit is picked directly from the original operand.
    function automatic logic [WIDTH:0] ref_shift(input logic [WIDTH-1:0] d, input int s, input logic [1:0] m);
        logic [WIDTH-1:0] r;
        logic c;
        for (int i = 0; i < WIDTH; i++) begin
            case (m)
                2'd0: r[i] = (i >= s) ? d[i-s] : 1'b0;
                2'd1: r[i] = (i + s < WIDTH) ? d[i+s] : 1'b0;
                2'd2: r[i] = (i + s < WIDTH) ? d[i+s] : d[WIDTH-1];
                default: r[i] = d[(i+s) % WIDTH];
            endcase
        end
        if (s == 0)        c = 1'b0;
        else if (m == 2'd0) c = d[WIDTH-s];
        else               c = d[s-1];
        return {c, r};
    endfunction

    typedef struct {
        logic [1:0]  m;
        logic [15:0] d;
        logic [3:0]  s;
        logic [15:0] r;
        logic        c;
    } vec_t;

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        n_checks++; if (out_carry !== 1'b0) begin n_fail++; $display("FAIL reset_out_carry got=%0b exp=0", out_carry); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        vec_t vecs[11];
        int lat;
        bit got;
        int exp_lat;
        vecs[0]  = '{2'd0, 16'h8001, 4'd1,  16'h0002, 1'b1};
        vecs[1]  = '{2'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0};
        vecs[2]  = '{2'd1, 16'h8000, 4'd15, 16'h0001, 1'b0};
        vecs[3]  = '{2'd3, 16'h1234, 4'd4,  16'h4123, 1'b0};
        vecs[4]  = '{2'd3, 16'h0001, 4'd1,  16'h8000, 1'b1};
        vecs[5]  = '{2'd3, 16'hC001, 4'd15, 16'h8003, 1'b1};
        vecs[6]  = '{2'd0, 16'h0001, 4'd15, 16'h8000, 1'b0};
        vecs[7]  = '{2'd0, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0};
        vecs[8]  = '{2'd1, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0};
        vecs[9]  = '{2'd2, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0};
        vecs[10] = '{2'd3, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = vecs[i].d; in_shamt = vecs[i].s; in_mode = vecs[i].m;
            lat = 0; got = 1'b0;
            while (lat < 20 && !got) begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
                if (out_valid) got = 1'b1;
            end
            exp_lat = (BYP && vecs[i].s == 0) ? 1 : SHAMT_W;
            n_checks++; if (!got) begin n_fail++; $display("FAIL dir%0d_timeout got=none exp=result", i); end
            n_checks++; if (out_data !== vecs[i].r) begin n_fail++; $display("FAIL dir%0d_data got=%h exp=%h", i, out_data, vecs[i].r); end
            n_checks++; if (out_carry !== vecs[i].c) begin n_fail++; $display("FAIL dir%0d_carry got=%0b exp=%0b", i, out_carry, vecs[i].c); end
            n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] got_q[$];
        logic [15:0] held;
        int sent = 0;
        int stall = 0;
        bit seen = 1'b0;
        bit holding = 1'b0;
        for (int cyc = 0; cyc < 60 && got_q.size() < 4; cyc++) begin
            @(negedge clk);
            out_ready = !(seen && stall < 3);
            #1;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                seen = 1'b1;
                holding = 1'b0;
            end else if (out_valid && !out_ready) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready got=%0b exp=0", in_ready); end
                if (holding) begin
                    n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL b2b_stall_data got=%h exp=%h", out_data, held); end
                end
                held = out_data;
                holding = 1'b1;
            end
            if (!out_ready) stall++;
            in_valid = (sent < 4); in_data = 16'h0001; in_shamt = 4'(sent); in_mode = 2'd0;
            #1;
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== 16'(1 << i)) begin
                n_fail++;
                $display("FAIL b2b_result%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, 16'(1 << i));
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        bit leaked = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'h1111 * 16'(i + 1); in_shamt = 4'(i + 1); in_mode = 2'(i);
        end
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL midreset_out_data got=%h exp=0000", out_data); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got=%0b exp=1", in_ready); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) leaked = 1'b1;
        end
        n_checks++; if (leaked) begin n_fail++; $display("FAIL midreset_leak got=result exp=none"); end
    endtask

    task automatic test_random();
        logic [WIDTH:0] exp_q[$];
        logic [WIDTH:0] e;
        int s;
        for (int cyc = 0; cyc < 440; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_unexpected got=%h exp=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_carry, out_data} !== e) begin
                        n_fail++;
                        $display("FAIL rand_result got=%0b/%h exp=%0b/%h", out_carry, out_data, e[WIDTH], e[WIDTH-1:0]);
                    end
                end
            end
            in_valid = (cyc < 400) && ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom);
            s        = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, WIDTH - 1));
            in_shamt = 4'(s);
            in_mode  = 2'($urandom_range(0, 3));
            #1;
            if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, s, in_mode));
        end
        in_valid = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain got=%0d left exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
